// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM states, access size codes,
// IO region tag and small byte helpers.
package mem_ctrl_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_READ  = 2'd1,
        LS_READ  = 2'd2,
        LS_WRITE = 2'd3
    } mc_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    // addr[17:16] value that marks the memory-mapped IO space
    localparam logic [1:0] IO_REGION = 2'b11;

    function automatic logic [CNT_W-1:0] xfer_len(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return CNT_W'(1);
            SIZE_HALF: return CNT_W'(2);
            default:   return CNT_W'(4);
        endcase
    endfunction

    function automatic logic [BYTE_W-1:0] word_byte(input logic [DATA_W-1:0] w,
                                                    input logic [1:0] idx);
        return BYTE_W'(w >> {idx, 3'b000});
    endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-wide memory controller: round-robin arbitration between instruction fetch
// and load/store unit, sequencing 1/2/4-byte little-endian transfers over an 8-bit RAM port.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_done_out,
    output logic [DATA_W-1:0] if_data_out,
    input  logic              ls_req_in,
    input  logic              ls_wr_in,
    input  logic [1:0]        ls_size_in,
    input  logic [ADDR_W-1:0] ls_addr_in,
    input  logic [DATA_W-1:0] ls_data_in,
    output logic              ls_done_out,
    output logic [DATA_W-1:0] ls_data_out,
    input  logic [BYTE_W-1:0] mem_din,
    output logic [BYTE_W-1:0] mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full,
    input  logic              roll_back
);

    mc_state_t         state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d, len, len_d, cnt_inc;
    logic [ADDR_W-1:0] addr, addr_d, mem_a_d;
    logic [DATA_W-1:0] wdata, wdata_d, rbuf, rbuf_d, rbuf_cap;
    logic [DATA_W-1:0] if_data_d, ls_data_d;
    logic [BYTE_W-1:0] mem_dout_d, din, din_hold;
    logic [1:0]        rd_lane;
    logic              last_if, last_if_d, wr_act, wr_act_d;
    logic              if_done_d, ls_done_d, grant_if, grant_ls, io_stall, rdy_q;

    // A byte returned while paused is kept so the capture after resume sees the right address
    assign din      = rdy_q ? mem_din : din_hold;
    assign io_stall = wr_act && (addr[17:16] == IO_REGION) && io_buffer_full;
    assign mem_wr   = wr_act && !io_stall;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state       <= IDLE;
            cnt         <= '0;
            len         <= '0;
            addr        <= '0;
            wdata       <= '0;
            rbuf        <= '0;
            last_if     <= 1'b0;
            wr_act      <= 1'b0;
            mem_a       <= '0;
            mem_dout    <= '0;
            if_done_out <= 1'b0;
            ls_done_out <= 1'b0;
            if_data_out <= '0;
            ls_data_out <= '0;
            rdy_q       <= 1'b0;
            din_hold    <= '0;
        end else begin
            rdy_q <= rdy_in;
            if (rdy_q) din_hold <= mem_din;
            if (rdy_in) begin
                state       <= state_d;
                cnt         <= cnt_d;
                len         <= len_d;
                addr        <= addr_d;
                wdata       <= wdata_d;
                rbuf        <= rbuf_d;
                last_if     <= last_if_d;
                wr_act      <= wr_act_d;
                mem_a       <= mem_a_d;
                mem_dout    <= mem_dout_d;
                if_done_out <= if_done_d;
                ls_done_out <= ls_done_d;
                if_data_out <= if_data_d;
                ls_data_out <= ls_data_d;
            end else begin
                if_done_out <= 1'b0;
                ls_done_out <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        len_d      = len;
        addr_d     = addr;
        wdata_d    = wdata;
        rbuf_d     = rbuf;
        last_if_d  = last_if;
        wr_act_d   = wr_act;
        mem_a_d    = mem_a;
        mem_dout_d = mem_dout;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_out;
        ls_data_d  = ls_data_out;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        cnt_inc    = cnt + CNT_W'(1);
        rd_lane    = 2'(cnt - CNT_W'(1));
        rbuf_cap   = rbuf | (DATA_W'(din) << {rd_lane, 3'b000});

        case (state)
            IDLE: begin
                // No grant on a done cycle or while a flush is signalled
                if (!roll_back && !if_done_out && !ls_done_out) begin
                    if (if_req_in && (!ls_req_in || !last_if)) grant_if = 1'b1;
                    else if (ls_req_in)                         grant_ls = 1'b1;
                end
                cnt_d  = '0;
                rbuf_d = '0;
                if (grant_if) begin
                    state_d   = IF_READ;
                    addr_d    = if_addr_in;
                    len_d     = CNT_W'(4);
                    mem_a_d   = if_addr_in;
                    last_if_d = 1'b1;
                end else if (grant_ls) begin
                    addr_d    = ls_addr_in;
                    len_d     = xfer_len(ls_size_in);
                    wdata_d   = ls_data_in;
                    mem_a_d   = ls_addr_in;
                    last_if_d = 1'b0;
                    if (ls_wr_in) begin
                        state_d    = LS_WRITE;
                        wr_act_d   = 1'b1;
                        mem_dout_d = word_byte(ls_data_in, 2'd0);
                    end else begin
                        state_d = LS_READ;
                    end
                end
            end

            IF_READ, LS_READ: begin
                // cnt counts issued addresses; byte cnt-1 is on mem_din this cycle
                if (roll_back) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    if (cnt != '0) rbuf_d = rbuf_cap;
                    if (cnt == len) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (state == IF_READ) begin
                            if_done_d = 1'b1;
                            if_data_d = rbuf_cap;
                        end else begin
                            ls_done_d = 1'b1;
                            ls_data_d = rbuf_cap;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc < len) mem_a_d = addr + ADDR_W'(cnt_inc);
                    end
                end
            end

            LS_WRITE: begin
                if (!io_stall) begin
                    if (cnt_inc == len) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        wr_act_d  = 1'b0;
                        ls_done_d = 1'b1;
                    end else begin
                        cnt_d      = cnt_inc;
                        mem_a_d    = addr + ADDR_W'(cnt_inc);
                        mem_dout_d = word_byte(wdata, 2'(cnt_inc));
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: arbitration, read/write sequencing, IO stall,
// roll-back, reset and pause behaviour against hand-computed expectations.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        if_req_in, if_done_out;
    logic [31:0] if_addr_in, if_data_out;
    logic        ls_req_in, ls_wr_in, ls_done_out;
    logic [1:0]  ls_size_in;
    logic [31:0] ls_addr_in, ls_data_in, ls_data_out;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full, roll_back;

    logic [7:0]  ram [0:1023];
    int          n_chk = 0;
    int          n_fail = 0;

    mem_ctrl dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .ls_req_in(ls_req_in), .ls_wr_in(ls_wr_in), .ls_size_in(ls_size_in),
        .ls_addr_in(ls_addr_in), .ls_data_in(ls_data_in),
        .ls_done_out(ls_done_out), .ls_data_out(ls_data_out),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .roll_back(roll_back)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous-read RAM: data for the address of cycle t appears in cycle t+1
    always @(posedge clk_in) mem_din <= ram[mem_a[9:0]];

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic ls_issue(input logic wr, input logic [1:0] size,
                            input logic [31:0] a, input logic [31:0] d);
        ls_req_in  = 1'b1;
        ls_wr_in   = wr;
        ls_size_in = size;
        ls_addr_in = a;
        ls_data_in = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h13; ram[10'h101] = 8'h05; ram[10'h102] = 8'h00; ram[10'h103] = 8'h00;
        ram[10'h200] = 8'hAA; ram[10'h201] = 8'hBB; ram[10'h202] = 8'hCC; ram[10'h203] = 8'hDD;

        rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; roll_back = 1'b0;
        ls_req_in = 1'b0; ls_wr_in = 1'b0; ls_size_in = 2'b00; ls_addr_in = '0; ls_data_in = '0;
        if_req_in = 1'b1; if_addr_in = 32'h100;
        step(); step();
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_if_done", 32'(if_done_out), 32'h0);
        chk("rst_ls_done", 32'(ls_done_out), 32'h0);
        chk("rst_if_data", if_data_out, 32'h0);
        chk("rst_ls_data", ls_data_out, 32'h0);
        if_req_in = 1'b0; rst_in = 1'b1;
        step();

        // Lone fetch of 0x100
        if_req_in = 1'b1; if_addr_in = 32'h100;
        step();
        if_req_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("if_addr", mem_a, 32'h100 + 32'(k));
            chk("if_rd_wr", 32'(mem_wr), 32'h0);
            step();
        end
        chk("if_done_early", 32'(if_done_out), 32'h0);
        step();
        chk("if_done", 32'(if_done_out), 32'h1);
        chk("if_data", if_data_out, 32'h0000_0513);
        step();
        chk("if_done_pulse", 32'(if_done_out), 32'h0);
        chk("if_data_hold", if_data_out, 32'h0000_0513);

        // Tie after reset: IF, then LS, then IF again
        rst_in = 1'b0; step(); rst_in = 1'b1;
        if_req_in = 1'b1; if_addr_in = 32'h100;
        ls_issue(1'b0, 2'b10, 32'h200, 32'h0);
        step();
        chk("tie1_if", mem_a, 32'h100);
        repeat (5) step();
        chk("tie1_if_done", 32'(if_done_out), 32'h1);
        chk("tie1_ls_quiet", 32'(ls_done_out), 32'h0);
        step();
        chk("no_grant_on_done", mem_a, 32'h103);
        step();
        chk("tie1_ls", mem_a, 32'h200);
        repeat (5) step();
        chk("ls_word_done", 32'(ls_done_out), 32'h1);
        chk("ls_word_data", ls_data_out, 32'hDDCC_BBAA);
        step();
        step();
        chk("tie2_if", mem_a, 32'h100);
        if_req_in = 1'b0; ls_req_in = 1'b0;
        repeat (5) step();
        chk("tie2_if_done", 32'(if_done_out), 32'h1);
        step();

        // Byte load, zero-extended
        ls_issue(1'b0, 2'b00, 32'h203, 32'h0);
        step();
        ls_req_in = 1'b0;
        chk("lb_addr", mem_a, 32'h203);
        step(); step();
        chk("lb_done", 32'(ls_done_out), 32'h1);
        chk("lb_data", ls_data_out, 32'h0000_00DD);
        step();

        // Half store across a 64K boundary
        ls_issue(1'b1, 2'b01, 32'h0001_FFFF, 32'h0000_BEEF);
        step();
        ls_req_in = 1'b0;
        chk("sh_a0", mem_a, 32'h0001_FFFF);
        chk("sh_d0", 32'(mem_dout), 32'hEF);
        chk("sh_w0", 32'(mem_wr), 32'h1);
        step();
        chk("sh_a1", mem_a, 32'h0002_0000);
        chk("sh_d1", 32'(mem_dout), 32'hBE);
        chk("sh_w1", 32'(mem_wr), 32'h1);
        chk("sh_done_early", 32'(ls_done_out), 32'h0);
        step();
        chk("sh_done", 32'(ls_done_out), 32'h1);
        chk("sh_wr_off", 32'(mem_wr), 32'h0);
        step();

        // Address wrap at 2^32
        ls_issue(1'b1, 2'b01, 32'hFFFF_FFFF, 32'h0000_1234);
        step();
        ls_req_in = 1'b0;
        chk("wrap_a0", mem_a, 32'hFFFF_FFFF);
        chk("wrap_d0", 32'(mem_dout), 32'h34);
        step();
        chk("wrap_a1", mem_a, 32'h0000_0000);
        chk("wrap_d1", 32'(mem_dout), 32'h12);
        step();
        chk("wrap_done", 32'(ls_done_out), 32'h1);
        step();

        // IO byte store held off by a full buffer for three cycles
        ls_issue(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041);
        step();
        ls_req_in = 1'b0; io_buffer_full = 1'b1; #1;
        for (int k = 0; k < 3; k++) begin
            chk("io_stall_wr", 32'(mem_wr), 32'h0);
            chk("io_stall_done", 32'(ls_done_out), 32'h0);
            step();
        end
        io_buffer_full = 1'b0; #1;
        chk("io_wr", 32'(mem_wr), 32'h1);
        chk("io_a", mem_a, 32'h0003_0000);
        chk("io_d", 32'(mem_dout), 32'h41);
        step();
        chk("io_done", 32'(ls_done_out), 32'h1);
        chk("io_wr_off", 32'(mem_wr), 32'h0);
        step();

        // Roll-back in A+2 of a word load; a fetch requested in A+3 must be granted at once
        ls_issue(1'b0, 2'b10, 32'h200, 32'h0);
        step();
        ls_req_in = 1'b0;
        step();
        roll_back = 1'b1;
        step();
        roll_back = 1'b0;
        if_req_in = 1'b1; if_addr_in = 32'h100;
        chk("rb_no_done", 32'(ls_done_out), 32'h0);
        step();
        if_req_in = 1'b0;
        chk("rb_idle_grant", mem_a, 32'h100);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rb_ls_quiet", 32'(ls_done_out), 32'h0);
        end
        chk("rb_if_done", 32'(if_done_out), 32'h1);
        chk("rb_if_data", if_data_out, 32'h0000_0513);
        step();

        // Roll-back in IDLE blocks the grant for that cycle only
        ls_issue(1'b0, 2'b00, 32'h203, 32'h0);
        roll_back = 1'b1;
        step();
        roll_back = 1'b0;
        chk("rb_idle_block", mem_a, 32'h103);
        step();
        ls_req_in = 1'b0;
        chk("rb_idle_late", mem_a, 32'h203);
        step(); step();
        chk("rb_idle_done", 32'(ls_done_out), 32'h1);
        chk("rb_idle_data", ls_data_out, 32'h0000_00DD);
        step();

        // Store is committed: roll-back has no effect
        ls_issue(1'b1, 2'b01, 32'h40, 32'h0000_A55A);
        step();
        ls_req_in = 1'b0; roll_back = 1'b1;
        chk("rbst_w0", 32'(mem_wr), 32'h1);
        chk("rbst_d0", 32'(mem_dout), 32'h5A);
        step();
        chk("rbst_w1", 32'(mem_wr), 32'h1);
        chk("rbst_a1", mem_a, 32'h41);
        chk("rbst_d1", 32'(mem_dout), 32'hA5);
        step();
        roll_back = 1'b0;
        chk("rbst_done", 32'(ls_done_out), 32'h1);
        step();

        // Reset in the middle of a word store
        ls_issue(1'b1, 2'b10, 32'h300, 32'h1122_3344);
        step();
        ls_req_in = 1'b0;
        chk("rst_st_d0", 32'(mem_dout), 32'h44);
        step();
        chk("rst_st_d1", 32'(mem_dout), 32'h33);
        rst_in = 1'b0;
        step();
        rst_in = 1'b1;
        chk("mid_rst_a", mem_a, 32'h0);
        chk("mid_rst_dout", 32'(mem_dout), 32'h0);
        chk("mid_rst_wr", 32'(mem_wr), 32'h0);
        chk("mid_rst_if_data", if_data_out, 32'h0);
        chk("mid_rst_ls_data", ls_data_out, 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("mid_rst_no_done", 32'(ls_done_out), 32'h0);
            chk("mid_rst_no_wr", 32'(mem_wr), 32'h0);
        end

        // Fetch paused for two cycles finishes two cycles late with correct data
        if_req_in = 1'b1; if_addr_in = 32'h100;
        step();
        if_req_in = 1'b0;
        chk("pause_a0", mem_a, 32'h100);
        step();
        chk("pause_a1", mem_a, 32'h101);
        rdy_in = 1'b0;
        step();
        chk("pause_hold1", mem_a, 32'h101);
        step();
        rdy_in = 1'b1;
        chk("pause_hold2", mem_a, 32'h101);
        step();
        chk("pause_a2", mem_a, 32'h102);
        step();
        chk("pause_not_yet", 32'(if_done_out), 32'h0);
        step();
        chk("pause_not_yet2", 32'(if_done_out), 32'h0);
        step();
        chk("pause_done", 32'(if_done_out), 32'h1);
        chk("pause_data", if_data_out, 32'h0000_0513);
        step();

        // Pause on the done cycle must not repeat the pulse
        if_req_in = 1'b1; if_addr_in = 32'h200;
        step();
        if_req_in = 1'b0;
        repeat (5) step();
        chk("dnr_done", 32'(if_done_out), 32'h1);
        chk("dnr_data", if_data_out, 32'hDDCC_BBAA);
        rdy_in = 1'b0;
        step();
        chk("dnr_no_repeat", 32'(if_done_out), 32'h0);
        chk("dnr_data_hold", if_data_out, 32'hDDCC_BBAA);
        rdy_in = 1'b1;
        step();
        chk("dnr_still_low", 32'(if_done_out), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk_in  in  1  system clock; rst_in  in  1  synchronous, active-low reset; rdy_in  in  1  pause when low.
REQ-002 SHALL have ports: if_req_in  in  1  fetch request; if_addr_in  in  32  fetch address; if_done_out  out  1  one-cycle completion pulse; if_data_out  out  32  fetched word.
REQ-003 SHALL have ports: ls_req_in  in  1  LSB request; ls_wr_in  in  1  1=store; ls_size_in  in  2  00=byte, 01=half, 10/11=word; ls_addr_in  in  32; ls_data_in  in  32  store data; ls_done_out  out  1  completion pulse; ls_data_out  out  32  load data, zero-extended.
REQ-004 SHALL have ports: mem_din  in  8  RAM read byte; mem_dout  out  8; mem_a  out  32; mem_wr  out  1  1=write; io_buffer_full  in  1; roll_back  in  1  mispredict flush.

Function
REQ-005 SHALL use states IDLE, IF_READ, LS_READ, LS_WRITE, with a 3-bit byte counter and a transfer length N of 1, 2 or 4 bytes (IF is always 4).
REQ-006 SHALL grant in IDLE when at least one request is high; the accept cycle is A.
REQ-007 SHALL break ties round-robin, granting the requester not granted last; a lone requester is granted immediately.
REQ-008 SHALL latch address, size and store data at grant; request inputs SHALL be ignored until IDLE is re-entered.
REQ-009 Read: SHALL drive mem_a = addr+k with mem_wr=0 in cycle A+1+k; SHALL capture mem_din as byte k (little-endian) at the end of cycle A+2+k; SHALL raise done with data valid in cycle A+N+2.
REQ-010 Write: SHALL drive mem_a = addr+k, mem_dout = data byte k and mem_wr=1 in cycle A+1+k; SHALL raise ls_done_out in cycle A+N+1.
REQ-011 SHALL compute addr+k modulo 2^32, so 0xFFFFFFFF+1 wraps to 0.
REQ-012 SHALL, for a write with addr[17:16]==2'b11 (IO space), issue no byte while io_buffer_full=1: mem_wr=0 and the counter holds, and the byte is issued on the first cycle io_buffer_full=0.
REQ-013 Done pulses SHALL last exactly one cycle; data outputs SHALL hold their value until the next completion.
REQ-014 SHALL return to IDLE on the done cycle and SHALL NOT grant in that cycle; the earliest next grant is the cycle after done.
REQ-015 roll_back in IF_READ or LS_READ SHALL abort the transfer: IDLE next cycle, no done, mem_wr=0.
REQ-016 roll_back SHALL NOT affect LS_WRITE, because stores are committed.
REQ-017 roll_back in IDLE SHALL suppress any grant in that cycle.
REQ-018 rdy_in=0 SHALL freeze all registers and outputs, except that done pulses SHALL NOT be repeated.
REQ-019 mem_wr SHALL be 0 in every cycle outside an active write byte.

Reset
REQ-020 rst_in=0 at a clock edge SHALL force state IDLE, counter 0, mem_a=0, mem_dout=0, mem_wr=0, both done outputs 0, both data outputs 0, and last-grant=LSB.
REQ-021 Reset SHALL take precedence over rdy_in and roll_back, and SHALL abort any transfer mid-operation with no done.

Structure
REQ-022 State encodings, size codes and the IO address-region constant SHALL reside in the shared header used by the other core blocks.
REQ-023 SHALL be a single module with no sub-module; the byte sequencing and the arbiter are one FSM.

Verification
REQ-024 IF read only, if_addr=0x100, RAM bytes 0x13,0x05,0x00,0x00 -> mem_a 0x100..0x103 in cycles A+1..A+4; if_done=1 in A+6 with if_data=0x00000513.
REQ-025 Simultaneous IF and LS requests after reset -> IF granted first; LS granted on the cycle after if_done; the next tie goes to IF.
REQ-026 Half store of 0xBEEF to 0x1FFFF -> writes 0xEF@0x1FFFF, 0xBE@0x20000; ls_done in A+3.
REQ-027 Byte store of 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those 3 cycles, then one write; done one cycle later.
REQ-028 roll_back in A+2 of an LS word load -> IDLE in A+3, ls_done never pulses; a concurrent store is unaffected by a roll_back.
REQ-029 rst_in=0 mid-store, and rdy_in=0 for 2 cycles mid-read -> reset gives all outputs 0 and IDLE; the paused read completes with correct data 2 cycles late.
